// File: rtl/mul_div_if.sv
// Request/result handshake bundle for the multiply/divide unit.
//   master: pipeline side (drives request, cancel, res_ready)
//   slave : mul_div_unit side (drives op_ready, res_valid, hi, lo, busy)
interface mul_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             op_valid;
  logic             op_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             cancel;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;

  modport master (
    output op_valid, op, src1, src2, cancel, res_ready,
    input  op_ready, res_valid, hi, lo, busy
  );

  modport slave (
    input  op_valid, op, src1, src2, cancel, res_ready,
    output op_ready, res_valid, hi, lo, busy
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit (MULT, MULTU, DIV, DIVU).
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// one iteration per cycle for WIDTH cycles, then a sign-fix cycle.
// Ports:
//   clk, resetn : rising-edge clock, asynchronous active-low reset
//   bus (slave) : op_valid/op_ready/op/src1/src2 request, cancel flush,
//                 res_valid/res_ready/hi/lo result, busy status
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic        clk,
  input logic        resetn,
  mul_div_if.slave   bus
);

  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_lo;
  logic             neg_hi;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd_b;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             res_valid_q;

  // Request decode, priority mult > multu > div > divu
  logic             sel_mult;
  logic             sel_multu;
  logic             sel_div;
  logic             sel_divu;
  logic             op_signed;
  logic             op_is_div;
  logic             op_none;
  logic             s1_neg;
  logic             s2_neg;
  logic             div_zero;
  logic             accept;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;

  assign sel_mult  = bus.op[0];
  assign sel_multu = ~bus.op[0] & bus.op[1];
  assign sel_div   = ~bus.op[0] & ~bus.op[1] & bus.op[2];
  assign sel_divu  = ~|bus.op[2:0] & bus.op[3];
  assign op_signed = sel_mult | sel_div;
  assign op_is_div = sel_div | sel_divu;
  assign op_none   = ~|bus.op;
  assign s1_neg    = op_signed & bus.src1[WIDTH-1];
  assign s2_neg    = op_signed & bus.src2[WIDTH-1];
  assign div_zero  = op_is_div & ~|bus.src2;
  assign mag1      = s1_neg ? (~bus.src1 + WIDTH'(1)) : bus.src1;
  assign mag2      = s2_neg ? (~bus.src2 + WIDTH'(1)) : bus.src2;
  assign accept    = bus.op_valid & (state == IDLE) & ~bus.cancel;

  // Multiply step: add multiplicand when multiplier LSB is set, then shift right
  logic [WIDTH:0]   msum;
  assign msum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);

  // Divide step: shift next dividend bit into the remainder, trial-subtract divisor.
  // Remainder < divisor keeps shifted < 2*divisor, so trial MSB is a clean borrow flag.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  assign shifted = {acc_hi, acc_lo[WIDTH-1]};
  assign trial   = shifted - {1'b0, opnd_b};

  // Sign-fix candidates
  logic [W2-1:0]    prod;
  logic [W2-1:0]    prod_neg;
  logic [WIDTH-1:0] quo_neg;
  logic [WIDTH-1:0] rem_neg;
  assign prod     = {acc_hi, acc_lo};
  assign prod_neg = ~prod + W2'(1);
  assign quo_neg  = ~acc_lo + WIDTH'(1);
  assign rem_neg  = ~acc_hi + WIDTH'(1);

  // State machine and datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd_b      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      res_valid_q <= 1'b0;
    end else if (bus.cancel) begin
      state       <= IDLE;
      res_valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (op_none) begin
              state       <= DONE;
              res_valid_q <= 1'b1;
              hi_q        <= '0;
              lo_q        <= '0;
            end else if (div_zero) begin
              state       <= DONE;
              res_valid_q <= 1'b1;
              hi_q        <= bus.src1;
              lo_q        <= '1;
            end else begin
              state  <= CALC;
              cnt    <= '0;
              is_div <= op_is_div;
              neg_lo <= s1_neg ^ s2_neg;
              neg_hi <= s1_neg;
              acc_hi <= '0;
              if (op_is_div) begin
                acc_lo <= mag1;
                opnd_b <= mag2;
              end else begin
                acc_lo <= mag2;
                opnd_b <= mag1;
              end
            end
          end
        end
        CALC: begin
          if (is_div) begin
            if (!trial[WIDTH]) begin
              acc_hi <= trial[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= shifted[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_hi <= msum[WIDTH:1];
            acc_lo <= {msum[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            lo_q <= neg_lo ? quo_neg : acc_lo;
            hi_q <= neg_hi ? rem_neg : acc_hi;
          end else begin
            {hi_q, lo_q} <= neg_lo ? prod_neg : prod;
          end
          state       <= DONE;
          res_valid_q <= 1'b1;
        end
        DONE: begin
          if (bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.op_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed and randomized operations
// compared against a 64-bit arithmetic reference model.
module tb_mul_div_unit;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  mul_div_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          edges;
  } vec_t;

  // Reference: plain 64-bit arithmetic; zero divisor / no-op finish on the accept edge
  function automatic vec_t ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    v.op = op; v.a = a; v.b = b; v.edges = 33;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = 64'(a); ub = 64'(b);
    if (op[0]) begin
      p = longint'(sa * sb); v.hi = 32'(p >> 32); v.lo = 32'(p);
    end else if (op[1]) begin
      p = ua * ub; v.hi = 32'(p >> 32); v.lo = 32'(p);
    end else if (op[2] || op[3]) begin
      if (b == 32'd0) begin
        v.hi = a; v.lo = 32'hFFFF_FFFF; v.edges = 0;
      end else if (op[2]) begin
        q = sa / sb; r = sa % sb; v.hi = 32'(r); v.lo = 32'(q);
      end else begin
        v.hi = 32'(ua % ub); v.lo = 32'(ua / ub);
      end
    end else begin
      v.hi = 32'd0; v.lo = 32'd0; v.edges = 0;
    end
    return v;
  endfunction

  // Drive one request and wait (bounded) for res_valid; edges = edges after the accept edge
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, output int edges);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = o; bus.src1 = a; bus.src2 = b;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    edges = 0;
    while (bus.res_valid !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic consume;
    @(negedge clk); bus.res_ready = 1'b1;
    @(posedge clk); #1; bus.res_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset res_valid got %b want 0", bus.res_valid); end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin errors++; $display("FAIL reset hi/lo got %h/%h want 0/0", bus.hi, bus.lo); end
    checks++; if (bus.busy !== 1'b0 || bus.op_ready !== 1'b1) begin errors++; $display("FAIL reset busy/op_ready got %b/%b want 0/1", bus.busy, bus.op_ready); end
  endtask

  task automatic test_mult;
    vec_t vq[$];
    vec_t v;
    int e;
    vq.push_back('{4'b0001, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    vq.push_back('{4'b0010, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 33});
    for (int i = 0; i < 10; i++) vq.push_back(ref_model(($urandom_range(0, 1) != 0) ? 4'b0001 : 4'b0010, $urandom, $urandom));
    foreach (vq[i]) begin
      v = vq[i];
      issue(v.op, v.a, v.b, e);
      checks++; if (e !== v.edges) begin errors++; $display("FAIL mult latency op=%b got %0d want %0d", v.op, e, v.edges); end
      checks++; if (bus.hi !== v.hi || bus.lo !== v.lo) begin errors++; $display("FAIL mult result op=%b %h*%h got %h_%h want %h_%h", v.op, v.a, v.b, bus.hi, bus.lo, v.hi, v.lo); end
      consume();
      checks++; if (bus.res_valid !== 1'b0 || bus.op_ready !== 1'b1) begin errors++; $display("FAIL mult consume res_valid/op_ready got %b/%b want 0/1", bus.res_valid, bus.op_ready); end
    end
  endtask

  task automatic test_div;
    vec_t vq[$];
    vec_t v;
    logic [31:0] a, b;
    int e;
    vq.push_back('{4'b0100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33});
    vq.push_back('{4'b1000, 32'h7, 32'h2, 32'h1, 32'h3, 33});
    vq.push_back('{4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33});
    vq.push_back('{4'b1000, 32'h5, 32'h0, 32'h5, 32'hFFFF_FFFF, 0});
    vq.push_back('{4'b0100, 32'hFFFF_FFFB, 32'h0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0});
    for (int i = 0; i < 14; i++) begin
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 2) == 0) b = 32'($urandom_range(0, 9)) ^ ({32{b[31]}});
      vq.push_back(ref_model(($urandom_range(0, 1) != 0) ? 4'b0100 : 4'b1000, a, b));
    end
    foreach (vq[i]) begin
      v = vq[i];
      issue(v.op, v.a, v.b, e);
      checks++; if (e !== v.edges) begin errors++; $display("FAIL div latency op=%b got %0d want %0d", v.op, e, v.edges); end
      checks++; if (bus.hi !== v.hi || bus.lo !== v.lo) begin errors++; $display("FAIL div result op=%b %h/%h got hi=%h lo=%h want hi=%h lo=%h", v.op, v.a, v.b, bus.hi, bus.lo, v.hi, v.lo); end
      consume();
      checks++; if (bus.res_valid !== 1'b0 || bus.op_ready !== 1'b1) begin errors++; $display("FAIL div consume res_valid/op_ready got %b/%b want 0/1", bus.res_valid, bus.op_ready); end
    end
  endtask

  task automatic test_op_decode;
    vec_t vq[$];
    vec_t v;
    int e;
    vq.push_back('{4'b0000, 32'h1234_5678, 32'h9, 32'h0, 32'h0, 0});
    vq.push_back('{4'b0110, 32'hFFFF_FFFF, 32'h2, 32'h1, 32'hFFFF_FFFE, 33});
    vq.push_back('{4'b1100, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33});
    vq.push_back('{4'b1111, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
    foreach (vq[i]) begin
      v = vq[i];
      issue(v.op, v.a, v.b, e);
      checks++; if (e !== v.edges) begin errors++; $display("FAIL decode latency op=%b got %0d want %0d", v.op, e, v.edges); end
      checks++; if (bus.hi !== v.hi || bus.lo !== v.lo) begin errors++; $display("FAIL decode result op=%b got %h_%h want %h_%h", v.op, bus.hi, bus.lo, v.hi, v.lo); end
      consume();
    end
  endtask

  task automatic test_cancel;
    int e;
    logic seen;
    issue(4'b0010, 32'h11, 32'h10, e);
    consume();
    // multu 0x11*0x10 = 0x110 is the last completed result
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 4'b0010; bus.src1 = 32'hDEAD_BEEF; bus.src2 = 32'h1234_5678;
    @(posedge clk); #1; bus.op_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); bus.cancel = 1'b1;
    @(posedge clk); #1; bus.cancel = 1'b0;
    checks++; if (bus.op_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL cancel op_ready/busy got %b/%b want 1/0", bus.op_ready, bus.busy); end
    checks++; if (bus.hi !== 32'h0 || bus.lo !== 32'h110) begin errors++; $display("FAIL cancel hi/lo kept got %h/%h want 0/110", bus.hi, bus.lo); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (bus.res_valid === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL cancel res_valid rose got %b want 0", seen); end
    issue(4'b0010, 32'd3, 32'd4, e);
    checks++; if (e !== 33 || bus.hi !== 32'd0 || bus.lo !== 32'd12) begin errors++; $display("FAIL cancel follow-up edges=%0d hi=%h lo=%h want 33/0/c", e, bus.hi, bus.lo); end
    consume();
  endtask

  task automatic test_back_to_back;
    int e;
    issue(4'b0001, 32'd7, 32'd9, e);
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd63) begin errors++; $display("FAIL hold first result got %h/%h want 0/3f", bus.hi, bus.lo); end
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 4'b0100; bus.src1 = 32'd100; bus.src2 = 32'd7;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.res_valid !== 1'b1 || bus.op_ready !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd63) begin
        errors++; $display("FAIL hold stable cyc=%0d res_valid=%b op_ready=%b hi=%h lo=%h", i, bus.res_valid, bus.op_ready, bus.hi, bus.lo);
      end
    end
    @(negedge clk); bus.res_ready = 1'b1;
    @(posedge clk); #1; bus.res_ready = 1'b0;
    checks++; if (bus.op_ready !== 1'b1 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL hold release op_ready/res_valid got %b/%b want 1/0", bus.op_ready, bus.res_valid); end
    @(posedge clk); #1; bus.op_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL back-to-back accept busy got %b want 1", bus.busy); end
    e = 0;
    while (bus.res_valid !== 1'b1 && e < 100) begin @(posedge clk); #1; e++; end
    checks++; if (e !== 33 || bus.hi !== 32'd2 || bus.lo !== 32'd14) begin errors++; $display("FAIL back-to-back div edges=%0d hi=%h lo=%h want 33/2/e", e, bus.hi, bus.lo); end
    consume();
  endtask

  task automatic test_async_reset;
    logic seen;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 4'b0001; bus.src1 = 32'hABCD; bus.src2 = 32'h77;
    @(posedge clk); #1; bus.op_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    checks++; if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0 || bus.op_ready !== 1'b1) begin errors++; $display("FAIL async reset res_valid/busy/op_ready got %b/%b/%b want 0/0/1", bus.res_valid, bus.busy, bus.op_ready); end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin errors++; $display("FAIL async reset hi/lo got %h/%h want 0/0", bus.hi, bus.lo); end
    @(negedge clk); resetn = 1'b1;
    // cancel and a request in the same cycle: nothing starts
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = 4'b0001; bus.src1 = 32'd5; bus.src2 = 32'd6; bus.cancel = 1'b1;
    @(posedge clk); #1; bus.op_valid = 1'b0; bus.cancel = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.op_ready !== 1'b1) begin errors++; $display("FAIL cancel+accept busy/op_ready got %b/%b want 0/1", bus.busy, bus.op_ready); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (bus.res_valid === 1'b1) seen = 1'b1; end
    checks++; if (seen !== 1'b0 || bus.lo !== 32'd0) begin errors++; $display("FAIL cancel+accept result appeared res_valid=%b lo=%h want 0/0", seen, bus.lo); end
  endtask

  initial begin
    checks = 0; errors = 0;
    resetn = 1'b0;
    bus.op_valid = 1'b0; bus.op = 4'b0; bus.src1 = '0; bus.src2 = '0;
    bus.cancel = 1'b0; bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    resetn = 1'b1;
    test_mult();
    test_div();
    test_op_decode();
    test_cancel();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
